operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand and writeback data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width (32 registers).
REQ-003 SHALL have parameter OP_WIDTH, default 8, opaque opcode passed through unchanged.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept an instruction this cycle.
- in_op  in  OP_WIDTH  opcode.
- in_rs1, in_rs2, in_rs3  in  ADDR_WIDTH each  source register addresses.
- in_rd  in  ADDR_WIDTH  destination register address.
- in_rd_en  in  1  instruction writes in_rd.
- read_addr_1/2/3  out  ADDR_WIDTH each  register-file read addresses.
- read_data_1/2/3  in  DATA_WIDTH each  register-file read data, combinational on read_addr_n.
- wb_en  in  1  writeback this cycle; identical to register-file write_en.
- wb_addr  in  ADDR_WIDTH  writeback address.
- wb_data  in  DATA_WIDTH  writeback data.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_op  out  OP_WIDTH  opcode.
- out_a, out_b, out_c  out  DATA_WIDTH each  operands for rs1, rs2, rs3.
- out_rd  out  ADDR_WIDTH  destination.
- out_rd_en  out  1  destination write enable.

Function
REQ-005 FSM SHALL have three states: EMPTY, READ, FULL.
REQ-006 EMPTY: in_ready=1; on in_valid, SHALL latch op/rs1-3/rd/rd_en into the instruction register and go to READ.
REQ-007 read_addr_n SHALL equal the latched rsN in all states, or 0 when no instruction is latched.
REQ-008 READ: hazard = busy[rs1] | busy[rs2] | busy[rs3] | (rd_en & busy[rd]); a busy bit cleared by wb_en in the same cycle SHALL NOT count.
REQ-009 READ with hazard SHALL remain in READ; in_ready=0; out_valid=0.
REQ-010 READ without hazard SHALL register operands into out_a/b/c, op, rd and rd_en, SHALL set busy[rd] if rd_en, and SHALL go to FULL.
REQ-011 Bypass: if wb_en and wb_addr==rsN on the capture cycle, operand N SHALL take wb_data, not read_data_N.
REQ-012 FULL: out_valid=1, outputs held stable; in_ready=out_ready.
REQ-013 FULL with out_ready and in_valid SHALL latch the new instruction and go to READ; with out_ready and no in_valid SHALL go to EMPTY; without out_ready SHALL stay in FULL.
REQ-014 Minimum latency: accept at cycle N gives out_valid at cycle N+2; peak throughput is one bundle per 2 cycles.
REQ-015 wb_en SHALL clear busy[wb_addr]; a clear to a non-busy address SHALL have no effect.
REQ-016 A set and a clear of the same busy bit in one cycle SHALL leave the bit set (the new producer wins).
REQ-017 in_ready SHALL be 0 in READ; in_valid SHALL be ignored whenever in_ready=0.

Reset
REQ-018 rst SHALL force state EMPTY, clear all busy bits and zero the instruction register and all out_* registers.
REQ-019 Out of reset: out_valid=0, in_ready=1, read_addr_n=0.
REQ-020 rst mid-operation SHALL discard any latched or presented instruction without handshake, with no partial busy update.

Structure
REQ-021 Package of_pkg SHALL hold the DATA/ADDR/OP width constants, the state enum and the instruction-register struct.
REQ-022 Busy tracking SHALL be a sub-module of_scoreboard (2^ADDR_WIDTH bits; set port, clear port, three source lookups plus rd lookup, same-cycle clear masking).

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- Regfile r3=0x1234, r4=0x00FF, r5=0xBEEF; issue rs=3,4,5 rd=6 rd_en=1 -> out_valid 2 cycles later, a/b/c=0x1234/0x00FF/0xBEEF, busy[6]=1.
- Issue rd=6, then rs1=6 -> stalls in READ; wb_en addr=6 data=0xCAFE -> same cycle captures out_a=0xCAFE.
- out_ready=0 for 5 cycles in FULL -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept.
- wb_en addr=6 clear and issue-set rd=6 in the same cycle -> busy[6]=1.
- WAW: rd=7 pending, new rd=7 with no sources busy -> stall until wb addr=7.
- rst asserted in READ with busy[6]=1 -> next cycle EMPTY, busy all 0, out_valid=0.

Source files
------------

// File: rtl/of_pkg.sv
// Shared widths, FSM state encoding and instruction-register layout for the
// operand fetch stage.
package of_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int OP_W     = 8;
  localparam int NUM_REGS = 1 << ADDR_W;

  // EMPTY: nothing held; READ: instruction latched, waiting for sources;
  // FULL: operand bundle presented downstream.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    READ  = 2'd1,
    FULL  = 2'd2
  } of_state_e;

  // Instruction register contents captured on the upstream handshake.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rs3;
    logic [ADDR_W-1:0] rd;
    logic              rd_en;
  } instr_t;

endpackage

// File: rtl/of_scoreboard.sv
// Register busy tracker: one bit per architectural register, set when a
// producer issues and cleared on its writeback. A clear arriving in the same
// cycle as a lookup already counts as not-busy, and a same-cycle set of the
// same bit wins over the clear.
module of_scoreboard
  import of_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rs3_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rs3_busy,
  output logic                  rd_busy
);

  localparam int NUM_BITS = 1 << ADDR_WIDTH;

  logic [NUM_BITS-1:0] busy_q;
  logic [NUM_BITS-1:0] set_mask;
  logic [NUM_BITS-1:0] clr_mask;
  logic [NUM_BITS-1:0] busy_eff;

  // Decode the set and clear ports into one-hot masks.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // Busy view with this cycle's writeback already retired.
  assign busy_eff = busy_q & ~clr_mask;

  assign rs1_busy = busy_eff[rs1_addr];
  assign rs2_busy = busy_eff[rs2_addr];
  assign rs3_busy = busy_eff[rs3_addr];
  assign rd_busy  = busy_eff[rd_addr];

  // Busy bit state: clear first, then OR in the new producer so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_eff | set_mask;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: latches one instruction, reads its three sources from
// the register file once no source (or the destination, for WAW) is pending,
// forwards a same-cycle writeback, and presents a registered operand bundle.
module operand_fetch
  import of_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int OP_WIDTH   = OP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in_op,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rs3,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [ADDR_WIDTH-1:0] read_addr_3,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2,
  input  logic [DATA_WIDTH-1:0] read_data_3,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   out_op,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_en
);

  of_state_e state_q;
  of_state_e state_d;

  instr_t ir_p0;
  logic   ir_load;
  logic   capture;
  logic   hazard;

  logic rs1_busy;
  logic rs2_busy;
  logic rs3_busy;
  logic rd_busy;

  logic [OP_WIDTH-1:0]   op_p1;
  logic [DATA_WIDTH-1:0] a_p1;
  logic [DATA_WIDTH-1:0] b_p1;
  logic [DATA_WIDTH-1:0] c_p1;
  logic [ADDR_WIDTH-1:0] rd_p1;
  logic                  rd_en_p1;

  // Register-file data unless the same register is being written back this
  // cycle, in which case the write data is the newer value.
  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  byp_en,
    input logic [ADDR_WIDTH-1:0] byp_addr,
    input logic [DATA_WIDTH-1:0] byp_data
  );
    return (byp_en && (byp_addr == rs)) ? byp_data : rf_data;
  endfunction

  of_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (capture & ir_p0.rd_en),
    .set_addr (ir_p0.rd),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .rs1_addr (ir_p0.rs1),
    .rs2_addr (ir_p0.rs2),
    .rs3_addr (ir_p0.rs3),
    .rd_addr  (ir_p0.rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rs3_busy (rs3_busy),
    .rd_busy  (rd_busy)
  );

  assign hazard = rs1_busy | rs2_busy | rs3_busy | (ir_p0.rd_en & rd_busy);

  // Source addresses follow the latched instruction; idle reads address 0.
  assign read_addr_1 = (state_q != EMPTY) ? ir_p0.rs1 : '0;
  assign read_addr_2 = (state_q != EMPTY) ? ir_p0.rs2 : '0;
  assign read_addr_3 = (state_q != EMPTY) ? ir_p0.rs3 : '0;

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ir_load   = 1'b0;
    capture   = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ir_load = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (!hazard) begin
          capture = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            ir_load = 1'b1;
            state_d = READ;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- stage p0: instruction register, loaded on the upstream handshake ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_p0 <= '0;
    end else if (ir_load) begin
      ir_p0.op    <= in_op;
      ir_p0.rs1   <= in_rs1;
      ir_p0.rs2   <= in_rs2;
      ir_p0.rs3   <= in_rs3;
      ir_p0.rd    <= in_rd;
      ir_p0.rd_en <= in_rd_en;
    end
  end

  // ---- stage p1: operand bundle, captured on the hazard-free READ cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p1    <= '0;
      a_p1     <= '0;
      b_p1     <= '0;
      c_p1     <= '0;
      rd_p1    <= '0;
      rd_en_p1 <= 1'b0;
    end else if (capture) begin
      op_p1    <= ir_p0.op;
      a_p1     <= select_operand(ir_p0.rs1, read_data_1, wb_en, wb_addr, wb_data);
      b_p1     <= select_operand(ir_p0.rs2, read_data_2, wb_en, wb_addr, wb_data);
      c_p1     <= select_operand(ir_p0.rs3, read_data_3, wb_en, wb_addr, wb_data);
      rd_p1    <= ir_p0.rd;
      rd_en_p1 <= ir_p0.rd_en;
    end
  end

  assign out_op    = op_p1;
  assign out_a     = a_p1;
  assign out_b     = b_p1;
  assign out_c     = c_p1;
  assign out_rd    = rd_p1;
  assign out_rd_en = rd_en_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file and a
// queue of expected operand bundles.
module tb_operand_fetch;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_op;
  logic [AW-1:0] in_rs1, in_rs2, in_rs3, in_rd;
  logic          in_rd_en;
  logic [AW-1:0] read_addr_1, read_addr_2, read_addr_3;
  logic [DW-1:0] read_data_1, read_data_2, read_data_3;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_op;
  logic [DW-1:0] out_a, out_b, out_c;
  logic [AW-1:0] out_rd;
  logic          out_rd_en;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [AW-1:0] rd;
    logic          rd_en;
  } bundle_t;

  bundle_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] rf [32];

  always #5 clk = ~clk;

  operand_fetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .OP_WIDTH  (OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rs3      (in_rs3),
    .in_rd       (in_rd),
    .in_rd_en    (in_rd_en),
    .read_addr_1 (read_addr_1),
    .read_addr_2 (read_addr_2),
    .read_addr_3 (read_addr_3),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .read_data_3 (read_data_3),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_rd      (out_rd),
    .out_rd_en   (out_rd_en)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      3:       return 16'h1234;
      4:       return 16'h00FF;
      5:       return 16'hBEEF;
      default: return 16'(i * 257);
    endcase
  endfunction

  // Register file model: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign read_data_1 = rf[read_addr_1];
  assign read_data_2 = rf[read_addr_2];
  assign read_data_3 = rf[read_addr_3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [AW-1:0] rs3,
                       input logic [AW-1:0] rd, input logic rd_en);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rs3   = rs3;
    in_rd    = rd;
    in_rd_en = rd_en;
  endtask

  task automatic push_exp(input logic [OW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] c,
                          input logic [AW-1:0] rd, input logic rd_en);
    bundle_t e;
    e.op = op; e.a = a; e.b = b; e.c = c; e.rd = rd; e.rd_en = rd_en;
    exp_q.push_back(e);
  endtask

  task automatic check_bundle(input string tag);
    bundle_t e;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".pending"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".op"},    32'(out_op),    32'(e.op));
      chk({tag, ".a"},     32'(out_a),     32'(e.a));
      chk({tag, ".b"},     32'(out_b),     32'(e.b));
      chk({tag, ".c"},     32'(out_c),     32'(e.c));
      chk({tag, ".rd"},    32'(out_rd),    32'(e.rd));
      chk({tag, ".rd_en"}, 32'(out_rd_en), 32'(e.rd_en));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    in_rd = '0; in_rd_en = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.ra1", 32'(read_addr_1), 32'd0);
    chk("rst.ra2", 32'(read_addr_2), 32'd0);
    chk("rst.ra3", 32'(read_addr_3), 32'd0);
    chk("rst.busy", dut.u_scoreboard.busy_q, 32'd0);

    // Basic fetch r3/r4/r5 -> rd 6, two-cycle latency.
    issue(8'h11, 5'd3, 5'd4, 5'd5, 5'd6, 1'b1);
    push_exp(8'h11, 16'h1234, 16'h00FF, 16'hBEEF, 5'd6, 1'b1);
    #1 chk("s1.in_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0; #1;
    chk("s1.read.out_valid", 32'(out_valid), 32'd0);
    chk("s1.read.in_ready", 32'(in_ready), 32'd0);
    chk("s1.read.ra1", 32'(read_addr_1), 32'd3);
    chk("s1.read.ra2", 32'(read_addr_2), 32'd4);
    chk("s1.read.ra3", 32'(read_addr_3), 32'd5);
    tick(); #1;
    check_bundle("s1");
    chk("s1.busy6", 32'(dut.u_scoreboard.busy_q[6]), 32'd1);

    // RAW on r6: stall until writeback, then forward the writeback data.
    issue(8'h22, 5'd6, 5'd0, 5'd1, 5'd8, 1'b1);
    #1 chk("s2.full.in_ready", 32'(in_ready), 32'd1);
    tick(); issue(8'hEE, 5'd9, 5'd9, 5'd9, 5'd9, 1'b1); #1;
    chk("s2.stall0.in_ready", 32'(in_ready), 32'd0);
    chk("s2.stall0.out_valid", 32'(out_valid), 32'd0);
    chk("s2.stall0.ra1", 32'(read_addr_1), 32'd6);
    tick(); #1;
    chk("s2.stall1.out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 16'hCAFE;
    push_exp(8'h22, 16'hCAFE, 16'h0000, 16'h0101, 5'd8, 1'b1);
    #1 chk("s2.wb.out_valid", 32'(out_valid), 32'd0);
    tick(); wb_en = 1'b0; out_ready = 1'b0;
    issue(8'h33, 5'd3, 5'd4, 5'd5, 5'd6, 1'b1); #1;
    check_bundle("s2");
    chk("s2.busy6", 32'(dut.u_scoreboard.busy_q[6]), 32'd0);
    chk("s2.busy8", 32'(dut.u_scoreboard.busy_q[8]), 32'd1);

    // Backpressure: bundle held stable, upstream blocked.
    for (int k = 0; k < 5; k++) begin
      chk("s3.hold.in_ready", 32'(in_ready), 32'd0);
      chk("s3.hold.out_valid", 32'(out_valid), 32'd1);
      chk("s3.hold.a", 32'(out_a), 32'hCAFE);
      chk("s3.hold.op", 32'(out_op), 32'h22);
      tick(); #1;
    end
    out_ready = 1'b1;
    push_exp(8'h33, 16'h1234, 16'h00FF, 16'hBEEF, 5'd6, 1'b1);
    #1 chk("s3.accept.in_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0; #1;
    chk("s3.read.out_valid", 32'(out_valid), 32'd0);
    chk("s3.read.ra1", 32'(read_addr_1), 32'd3);
    tick(); #1;
    check_bundle("s3");
    chk("s3.busy6", 32'(dut.u_scoreboard.busy_q[6]), 32'd1);

    // WAW on r6 resolved by a same-cycle clear; the new set must survive.
    issue(8'h44, 5'd3, 5'd4, 5'd5, 5'd6, 1'b1);
    push_exp(8'h44, 16'h1234, 16'h00FF, 16'hBEEF, 5'd6, 1'b1);
    tick(); in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 16'h5555; #1;
    chk("s4.read.out_valid", 32'(out_valid), 32'd0);
    tick(); wb_en = 1'b0; #1;
    check_bundle("s4");
    chk("s4.busy6", 32'(dut.u_scoreboard.busy_q[6]), 32'd1);

    // WAW on r7 with free sources: stall until r7 is written back.
    issue(8'h55, 5'd1, 5'd2, 5'd0, 5'd7, 1'b1);
    push_exp(8'h55, 16'h0101, 16'h0202, 16'h0000, 5'd7, 1'b1);
    tick(); in_valid = 1'b0; #1;
    tick(); #1;
    check_bundle("s5a");
    chk("s5a.busy7", 32'(dut.u_scoreboard.busy_q[7]), 32'd1);
    issue(8'h66, 5'd3, 5'd4, 5'd5, 5'd7, 1'b1);
    tick(); in_valid = 1'b0; #1;
    chk("s5.waw0.out_valid", 32'(out_valid), 32'd0);
    tick(); #1;
    chk("s5.waw1.out_valid", 32'(out_valid), 32'd0);
    chk("s5.waw1.in_ready", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 16'h7777;
    push_exp(8'h66, 16'h1234, 16'h00FF, 16'hBEEF, 5'd7, 1'b1);
    tick(); wb_en = 1'b0; #1;
    check_bundle("s5b");
    chk("s5b.busy7", 32'(dut.u_scoreboard.busy_q[7]), 32'd1);

    // Busy destination does not stall when the instruction does not write it.
    issue(8'h77, 5'd3, 5'd4, 5'd5, 5'd7, 1'b0);
    push_exp(8'h77, 16'h1234, 16'h00FF, 16'hBEEF, 5'd7, 1'b0);
    tick(); in_valid = 1'b0; #1;
    tick(); #1;
    check_bundle("s5c");

    // Reset while stalled in READ on busy r6.
    issue(8'h88, 5'd6, 5'd3, 5'd4, 5'd10, 1'b1);
    tick(); in_valid = 1'b0; #1;
    chk("s6.stall.out_valid", 32'(out_valid), 32'd0);
    chk("s6.stall.in_ready", 32'(in_ready), 32'd0);
    tick(); #1;
    chk("s6.busy6", 32'(dut.u_scoreboard.busy_q[6]), 32'd1);
    rst = 1'b1; issue(8'h99, 5'd1, 5'd2, 5'd3, 5'd11, 1'b1);
    tick(); rst = 1'b0; in_valid = 1'b0; #1;
    chk("s6.rst.in_ready", 32'(in_ready), 32'd1);
    chk("s6.rst.out_valid", 32'(out_valid), 32'd0);
    chk("s6.rst.ra1", 32'(read_addr_1), 32'd0);
    chk("s6.rst.busy", dut.u_scoreboard.busy_q, 32'd0);
    chk("s6.rst.out_a", 32'(out_a), 32'd0);
    chk("s6.rst.out_rd_en", 32'(out_rd_en), 32'd0);
    tick(); #1;
    chk("s6.idle.out_valid", 32'(out_valid), 32'd0);
    chk("end.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
